// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding instruction-memory handshake, IF/ID register.
// A one-entry skid buffer parks a word that returns during a stall; DROP swallows a stale reply after a redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        fail,
  input  logic        data_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] PC_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_if_r, pc_if_s;
  logic [31:0] pc_id_r, pc_id_s;
  logic [31:0] inst_id_r, inst_id_s;
  logic        valid_id_r, valid_id_s;
  logic [31:0] buf_pc_r, buf_pc_s;
  logic [31:0] buf_inst_r, buf_inst_s;

  // Next-state and next-register computation; every path starts from "hold".
  always_comb begin
    state_s    = state_r;
    pc_if_s    = pc_if_r;
    pc_id_s    = pc_id_r;
    inst_id_s  = inst_id_r;
    valid_id_s = valid_id_r;
    buf_pc_s   = buf_pc_r;
    buf_inst_s = buf_inst_r;
    case (state_r)
      FETCH: begin
        if (data_stall) begin
          if (imem_ack) begin
            buf_pc_s   = pc_if_r;
            buf_inst_s = imem_rdata;
            state_s    = HOLD;
          end else begin
            state_s = FETCH;
          end
        end else if (fail) begin
          // A reply arriving with the redirect is discarded; otherwise it is still in flight.
          inst_id_s  = NOP_INST;
          valid_id_s = 1'b0;
          pc_if_s    = npc;
          if (imem_ack) begin
            state_s = FETCH;
          end else begin
            state_s = DROP;
          end
        end else if (imem_ack) begin
          pc_id_s    = pc_if_r;
          inst_id_s  = imem_rdata;
          valid_id_s = 1'b1;
          pc_if_s    = npc;
        end else begin
          inst_id_s  = NOP_INST;
          valid_id_s = 1'b0;
        end
      end
      HOLD: begin
        if (data_stall) begin
          state_s = HOLD;
        end else if (fail) begin
          inst_id_s  = NOP_INST;
          valid_id_s = 1'b0;
          pc_if_s    = npc;
          state_s    = FETCH;
        end else begin
          pc_id_s    = buf_pc_r;
          inst_id_s  = buf_inst_r;
          valid_id_s = 1'b1;
          pc_if_s    = npc;
          state_s    = FETCH;
        end
      end
      DROP: begin
        // The stale reply retires the old request even while ID is stalled.
        if (imem_ack) begin
          state_s = FETCH;
        end else begin
          state_s = DROP;
        end
        if (data_stall) begin
          valid_id_s = valid_id_r;
        end else begin
          inst_id_s  = NOP_INST;
          valid_id_s = 1'b0;
          if (fail) begin
            pc_if_s = npc;
          end else begin
            pc_if_s = pc_if_r;
          end
        end
      end
      default: begin
        state_s    = FETCH;
        inst_id_s  = NOP_INST;
        valid_id_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH;
      pc_if_r    <= RESET_PC;
      pc_id_r    <= 32'h0000_0000;
      inst_id_r  <= NOP_INST;
      valid_id_r <= 1'b0;
      buf_pc_r   <= 32'h0000_0000;
      buf_inst_r <= NOP_INST;
    end else begin
      state_r    <= state_s;
      pc_if_r    <= pc_if_s;
      pc_id_r    <= pc_id_s;
      inst_id_r  <= inst_id_s;
      valid_id_r <= valid_id_s;
      buf_pc_r   <= buf_pc_s;
      buf_inst_r <= buf_inst_s;
    end
  end

  assign imem_req   = (state_r == FETCH);
  assign imem_addr  = pc_if_r;
  assign fetch_busy = ((state_r == FETCH) && !imem_ack) || (state_r == DROP);
  assign PC_IF      = pc_if_r;
  assign PC_ID      = pc_id_r;
  assign inst_ID    = inst_id_r;
  assign valid_ID   = valid_id_r;

endmodule
